packet_dispatcher: RTL

Transmit-side NoC adapter: accepts result words from a local compute stage through a FIFO push interface and emits them as fixed-length AXI-Stream packets toward a remote collector. Each packet is PKT_BEATS beats, with tlast on the final beat. Destination is selected per packet. Sits directly upstream of the NoC Rx collector: its tx stream is the collector's rx stream after NoC traversal.

---
 rtl/noc_pkg.sv | 25 ++
 rtl/fifo.sv | 64 ++++++
 rtl/packet_dispatcher.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// ============================================================================
// noc_pkg
// Shared NoC adapter types: dispatcher FSM states, sequence width, tuser packing.
// Revision: 1.0
// ============================================================================
`default_nettype none

package noc_pkg;

    localparam int c_SEQ_W       = 16;
    localparam int c_TUSER_MAX_W = 128;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Zero-extends the packet sequence number; callers size-cast to their tuser width.
    function automatic logic [c_TUSER_MAX_W-1:0] pack_tuser(input logic [c_SEQ_W-1:0] seq);
        return {{(c_TUSER_MAX_W - c_SEQ_W){1'b0}}, seq};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo.sv
// ============================================================================
// fifo
// Show-ahead synchronous FIFO; pushes while full are dropped.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] idata,
    output logic [WIDTH-1:0] odata,
    output logic             empty,
    output logic             full,
    output logic             almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_FULL_LVL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_AFULL_LVL = (AW+1)'(DEPTH - 2);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign w_wr = push & ~full;
    assign w_rd = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= idata;
    end

    assign odata       = r_mem[r_rptr];
    assign empty       = (r_count == '0);
    assign full        = (r_count == c_FULL_LVL);
    assign almost_full = (r_count >= c_AFULL_LVL);

endmodule

`default_nettype wire

// File: rtl/packet_dispatcher.sv
// ============================================================================
// packet_dispatcher
// Buffers result words and emits fixed-length AXI-Stream packets to the NoC.
// Optional build macro: DISPATCHER_DEST_RR_EN (round-robin tdest, dest_in unused).
// Revision: 1.0
// ============================================================================
`default_nettype none

module packet_dispatcher
    import noc_pkg::*;
#(
    parameter int DATAW     = 512,
    parameter int BYTEW     = 8,
    parameter int IDW       = 32,
    parameter int DESTW     = 7,
    parameter int USERW     = 75,
    parameter int DATAUSERW = DATAW + USERW,
    parameter int DEPTH     = 64,
    parameter int PKT_BEATS = 4,
    parameter int SRC_ID    = 0,
    parameter int NUM_DEST  = 4,
    parameter int BASE_DEST = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_fifo_wen,
    input  logic [DATAW-1:0]     data_fifo_wdata,
    output logic                 data_fifo_rdy,
    input  logic [DESTW-1:0]     dest_in,
    output logic                 axis_tx_tvalid,
    input  logic                 axis_tx_tready,
    output logic [DATAUSERW-1:0] axis_tx_tdata,
    output logic [BYTEW-1:0]     axis_tx_tstrb,
    output logic [BYTEW-1:0]     axis_tx_tkeep,
    output logic [IDW-1:0]       axis_tx_tid,
    output logic [DESTW-1:0]     axis_tx_tdest,
    output logic [USERW-1:0]     axis_tx_tuser,
    output logic                 axis_tx_tlast,
    output logic [31:0]          pkt_count
);

    localparam int BCW  = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
    localparam int OCCW = $clog2(DEPTH) + 1;
    localparam logic [BCW-1:0]  c_LAST_BEAT = BCW'(PKT_BEATS - 1);
    localparam logic [OCCW-1:0] c_OCC_ONE   = OCCW'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BCW-1:0]      r_beat;
    logic [DESTW-1:0]    r_dest;
    logic [DESTW-1:0]    w_dest_sel;
    logic [c_SEQ_W-1:0]  r_seq;
    logic [31:0]         r_pkt_count;
    logic [OCCW-1:0]     r_occ;
    logic [DATAW-1:0]    w_head;
    logic                w_empty;
    logic                w_full;
    logic                w_afull;
    logic                w_push;
    logic                w_hs;
    logic                w_last;
    logic                w_complete;
    logic                w_will_empty;
    logic                w_start;

    fifo #(
        .WIDTH (DATAW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (data_fifo_wen),
        .pop         (w_hs),
        .idata       (data_fifo_wdata),
        .odata       (w_head),
        .empty       (w_empty),
        .full        (w_full),
        .almost_full (w_afull)
    );

    assign w_push       = data_fifo_wen & ~w_full;
    assign w_hs         = (r_state == ST_SEND) & ~w_empty & axis_tx_tready;
    assign w_last       = (r_beat == c_LAST_BEAT);
    assign w_complete   = w_hs & w_last;
    // Occupancy mirror lets the last beat decide between IDLE and a seamless next packet.
    assign w_will_empty = (r_occ == c_OCC_ONE) & ~w_push;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        axis_tx_tvalid = 1'b0;
        w_start        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                axis_tx_tvalid = ~w_empty;
                if (w_complete) begin
                    if (w_will_empty) w_state_nxt = ST_IDLE;
                    else              w_start     = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef DISPATCHER_DEST_RR_EN
    localparam logic [DESTW-1:0] c_RR_LAST = DESTW'(NUM_DEST - 1);
    localparam logic [DESTW-1:0] c_RR_BASE = DESTW'(BASE_DEST);

    logic [DESTW-1:0] r_rr_idx;
    logic [DESTW-1:0] w_rr_next;

    assign w_rr_next  = (r_rr_idx == c_RR_LAST) ? '0 : r_rr_idx + 1'b1;
    // A back-to-back start coincides with completion, so it must take the advanced slot.
    assign w_dest_sel = c_RR_BASE + (w_complete ? w_rr_next : r_rr_idx);

    always_ff @(posedge clk) begin
        if (rst)             r_rr_idx <= '0;
        else if (w_complete) r_rr_idx <= w_rr_next;
    end
`else
    assign w_dest_sel = dest_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat      <= '0;
            r_dest      <= '0;
            r_seq       <= '0;
            r_pkt_count <= '0;
            r_occ       <= '0;
        end else begin
            if (w_start || w_complete) r_beat <= '0;
            else if (w_hs)             r_beat <= r_beat + 1'b1;

            if (w_start) r_dest <= w_dest_sel;

            if (w_complete) begin
                r_seq       <= r_seq + 1'b1;
                r_pkt_count <= r_pkt_count + 1'b1;
            end

            case ({w_push, w_hs})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign data_fifo_rdy = ~rst & ~w_afull;
    assign axis_tx_tdata = {{USERW{1'b0}}, w_head};
    assign axis_tx_tstrb = '1;
    assign axis_tx_tkeep = '1;
    assign axis_tx_tid   = IDW'(SRC_ID);
    assign axis_tx_tdest = r_dest;
    assign axis_tx_tuser = USERW'(pack_tuser(r_seq));
    assign axis_tx_tlast = (r_state == ST_SEND) & w_last;
    assign pkt_count     = r_pkt_count;

endmodule

`default_nettype wire
